// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants and enums for the instruction encoder and the main decoder.
package instr_encoder_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_R  = 3'b000,
        CLS_I  = 3'b001,
        CLS_LW = 3'b010,
        CLS_SW = 3'b011,
        CLS_BR = 3'b100
    } op_class_e;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FULL   = 2'd2
    } state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Packs one instruction descriptor into a 32-bit RV32I word and flags unencodable descriptors.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic              [2:0]  op_class,
    input  logic              [2:0]  funct3,
    input  logic                     funct7b5,
    input  logic              [4:0]  rd,
    input  logic              [4:0]  rs1,
    input  logic              [4:0]  rs2,
    input  logic signed       [12:0] imm,
    output logic              [31:0] word,
    output logic                     illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_class)
            CLS_R:  word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OPC_R};
            CLS_I: begin
                // Shift-immediates carry the shift type in bit 30 and only a 5-bit shamt.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OPC_I};
                else
                    word = {imm[11:0], rs1, funct3, rd, OPC_I};
            end
            CLS_LW: word = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
            CLS_SW: word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
            CLS_BR: begin
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
                illegal = imm[0] || (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Accepts instruction descriptors, encodes them and writes them sequentially into instruction memory.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              op_class,
    input  logic [2:0]              funct3,
    input  logic                    funct7b5,
    input  logic [4:0]              rd,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic signed [12:0]      imm,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [ADDR_WIDTH-2:0]   count,
    output logic                    full,
    output logic                    err_illegal
);

    state_e                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-2:0]   cnt;
    logic                    err;
    logic [31:0]             word_pk;
    logic                    ill_pk;
    logic [31:0]             word_p0;
    logic                    hs;
    logic                    last_word;

    instr_field_pack u_pack (
        .op_class (op_class),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .word     (word_pk),
        .illegal  (ill_pk)
    );

    assign hs        = in_valid && in_ready;
    assign last_word = &ptr[ADDR_WIDTH-1:2];

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_ACCEPT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_ACCEPT;
        end else begin
            case (state)
                ST_ACCEPT: if (hs && !ill_pk) state_nxt = ST_WRITE;
                ST_WRITE:  state_nxt = last_word ? ST_FULL : ST_ACCEPT;
                ST_FULL:   state_nxt = ST_FULL;
                default:   state_nxt = ST_ACCEPT;
            endcase
        end
    end

    always_comb begin
        in_ready = (state == ST_ACCEPT) && !clear;
        mem_we   = (state == ST_WRITE) && !clear && !rst;
        full     = (state == ST_FULL);
    end

    // Stage p0: encoded word held for the write cycle
    always_ff @(posedge clk) begin
        if (hs)
            word_p0 <= word_pk;
    end

    // The pointer parks on the last word once full so it only returns to 0 via clear/rst.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state == ST_WRITE) begin
                cnt <= cnt + 1'b1;
                if (!last_word)
                    ptr <= ptr + ADDR_WIDTH'(4);
            end
            if (hs && ill_pk)
                err <= 1'b1;
        end
    end

    assign mem_addr    = ptr;
    assign mem_wdata   = mem_we ? word_p0 : '0;
    assign count       = cnt;
    assign err_illegal = err;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors followed by randomized descriptor traffic.
module tb_instr_encoder;

    localparam int AW  = 4;
    localparam int CAP = 1 << (AW - 2);

    typedef struct packed {
        logic [2:0]  oc;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
    } desc_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic               clk;
    logic               rst;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         op_class;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic signed [12:0] imm;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [31:0]        mem_wdata;
    logic [AW-2:0]      count;
    logic               full;
    logic               err_illegal;

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_class    (op_class),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .count       (count),
        .full        (full),
        .err_illegal (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    wr_t exp_q[$];

    // Reference model state
    logic [AW-1:0] m_ptr  = '0;
    int            m_cnt  = 0;
    bit            m_err  = 0;
    bit            m_full = 0;
    bit            m_pend = 0;
    logic [31:0]   m_word = '0;

    // Expected outputs for the current cycle
    bit            chk_en   = 0;
    bit            e_we     = 0;
    bit            e_ready  = 0;
    bit            e_full   = 0;
    bit            e_err    = 0;
    bit            e_rstval = 0;
    int            e_cnt    = 0;
    logic [AW-1:0] e_addr   = '0;

    int            n_writes   = 0;
    logic [AW-1:0] last_addr  = '0;
    logic [31:0]   last_wdata = '0;
    bit            prev_we    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Instruction word from the ISA field layout, built by positional arithmetic.
    function automatic logic [32:0] ref_enc(desc_t d);
        logic [31:0] w;
        bit          ill;
        w   = 32'h0;
        ill = 0;
        case (d.oc)
            3'd0: w = (32'(d.f7) << 30) + (32'(d.rs2) << 20) + (32'(d.rs1) << 15)
                      + (32'(d.f3) << 12) + (32'(d.rd) << 7) + 32'h33;
            3'd1: begin
                if (d.f3 == 3'd1 || d.f3 == 3'd5)
                    w = (32'(d.f7) << 30) + (32'(d.imm[4:0]) << 20);
                else
                    w = 32'(d.imm[11:0]) << 20;
                w = w + (32'(d.rs1) << 15) + (32'(d.f3) << 12) + (32'(d.rd) << 7) + 32'h13;
            end
            3'd2: w = (32'(d.imm[11:0]) << 20) + (32'(d.rs1) << 15) + (32'd2 << 12)
                      + (32'(d.rd) << 7) + 32'h03;
            3'd3: w = (32'(d.imm[11:5]) << 25) + (32'(d.rs2) << 20) + (32'(d.rs1) << 15)
                      + (32'd2 << 12) + (32'(d.imm[4:0]) << 7) + 32'h23;
            3'd4: begin
                ill = d.imm[0] || d.f3 == 3'd2 || d.f3 == 3'd3;
                w = (32'(d.imm[12]) << 31) + (32'(d.imm[10:5]) << 25) + (32'(d.rs2) << 20)
                    + (32'(d.rs1) << 15) + (32'(d.f3) << 12) + (32'(d.imm[4:1]) << 8)
                    + (32'(d.imm[11]) << 7) + 32'h63;
            end
            default: ill = 1;
        endcase
        return {ill, w};
    endfunction

    function automatic desc_t mk(input int oc, input int f3, input int f7, input int rd_,
                                 input int rs1_, input int rs2_, input int im);
        desc_t d;
        d.oc  = 3'(oc);
        d.f3  = 3'(f3);
        d.f7  = 1'(f7);
        d.rd  = 5'(rd_);
        d.rs1 = 5'(rs1_);
        d.rs2 = 5'(rs2_);
        d.imm = 13'(im);
        return d;
    endfunction

    task automatic step(input bit r, input bit c, input bit v, input desc_t d);
        logic [32:0] enc;
        rst      = r;
        clear    = c;
        in_valid = v;
        op_class = d.oc;
        funct3   = d.f3;
        funct7b5 = d.f7;
        rd       = d.rd;
        rs1      = d.rs1;
        rs2      = d.rs2;
        imm      = d.imm;
        e_we    = m_pend && !c && !r;
        e_ready = !m_pend && !m_full && !c;
        e_full  = m_full;
        e_err   = m_err;
        e_cnt   = m_cnt;
        e_addr  = m_ptr;
        if (e_we)
            exp_q.push_back({m_ptr, m_word});
        @(posedge clk);
        enc = ref_enc(d);
        if (r || c) begin
            m_ptr  = '0;
            m_cnt  = 0;
            m_err  = 0;
            m_full = 0;
            m_pend = 0;
        end else if (m_pend) begin
            m_pend = 0;
            m_cnt++;
            if (m_cnt == CAP) m_full = 1;
            else              m_ptr  = m_ptr + AW'(4);
        end else if (v && e_ready) begin
            if (enc[32]) m_err = 1;
            else begin
                m_pend = 1;
                m_word = enc[31:0];
            end
        end
        e_rstval = r;
        chk_en   = 1;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("in_ready", 32'(in_ready), 32'(e_ready));
            check("full", 32'(full), 32'(e_full));
            check("err_illegal", 32'(err_illegal), 32'(e_err));
            check("count", 32'(count), 32'(e_cnt));
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            check("we_back_to_back", 32'(prev_we && mem_we), 32'(0));
            if (e_rstval)
                check("rst_wdata", mem_wdata, 32'h0);
            prev_we = mem_we;
            if (mem_we) begin
                n_writes++;
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
                check("write_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(w.addr));
                    check("wr_data", mem_wdata, w.data);
                end
            end else if (e_we && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        desc_t idle, d_add, d_sub, d_lw, d_beq, d_bad, d;
        int    base;
        idle  = '0;
        d_add = mk(0, 0, 0, 3, 1, 2, 0);
        d_sub = mk(0, 0, 1, 3, 1, 2, 0);
        d_lw  = mk(2, 0, 0, 5, 2, 0, 8);
        d_beq = mk(4, 0, 0, 0, 1, 2, -4);
        d_bad = mk(6, 0, 0, 1, 1, 1, 0);

        step(1, 0, 0, idle);
        step(1, 0, 0, idle);

        // add / sub
        step(0, 0, 1, d_add);
        step(0, 0, 0, idle);
        check("add_addr", 32'(last_addr), 32'h0);
        check("add_word", last_wdata, 32'h002081B3);
        step(0, 1, 0, idle);
        step(0, 0, 1, d_sub);
        step(0, 0, 0, idle);
        check("sub_addr", 32'(last_addr), 32'h0);
        check("sub_word", last_wdata, 32'h402081B3);

        // lw then beq
        step(0, 1, 0, idle);
        step(0, 0, 1, d_lw);
        step(0, 0, 0, idle);
        check("lw_word", last_wdata, 32'h00812283);
        step(0, 0, 1, d_beq);
        step(0, 0, 0, idle);
        check("beq_addr", 32'(last_addr), 32'h4);
        check("beq_word", last_wdata, 32'hFE208EE3);
        check("lw_beq_count", 32'(count), 32'd2);

        // illegal op_class then a legal descriptor at the same address
        step(0, 1, 0, idle);
        base = n_writes;
        step(0, 0, 1, d_bad);
        step(0, 0, 0, idle);
        check("illegal_nowrite", 32'(n_writes - base), 32'd0);
        check("illegal_flag", 32'(err_illegal), 32'd1);
        check("illegal_count", 32'(count), 32'd0);
        step(0, 0, 1, d_lw);
        step(0, 0, 0, idle);
        check("after_illegal_addr", 32'(last_addr), 32'h0);
        check("after_illegal_flag", 32'(err_illegal), 32'd1);

        // fill the memory with back-to-back descriptors
        step(0, 1, 0, idle);
        base = n_writes;
        for (int i = 0; i < 10; i++)
            step(0, 0, 1, mk(1, 0, 0, i + 1, 0, 0, i));
        check("fill_writes", 32'(n_writes - base), 32'd4);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(count), 32'd4);
        check("fill_last_addr", 32'(last_addr), 32'hC);

        // clear during the write cycle
        step(0, 1, 0, idle);
        step(0, 0, 1, d_lw);
        step(0, 1, 0, idle);
        check("clr_wr_count", 32'(count), 32'd0);
        check("clr_wr_full", 32'(full), 32'd0);
        step(0, 0, 1, d_add);
        step(0, 0, 0, idle);
        check("clr_wr_next_addr", 32'(last_addr), 32'h0);

        // rst dominating clear and a valid descriptor
        step(0, 0, 1, d_add);
        step(1, 1, 1, d_add);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata_now", mem_wdata, 32'h0);
        check("rst_count", 32'(count), 32'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            d.oc  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            d.f3  = 3'($urandom);
            d.f7  = 1'($urandom);
            d.rd  = 5'($urandom);
            d.rs1 = 5'($urandom);
            d.rs2 = 5'($urandom);
            d.imm = 13'($urandom);
            if (d.oc == 3'd4)
                d.imm[0] = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 99) == 0,
                 m_full ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0),
                 $urandom_range(0, 3) != 0, d);
        end
        step(0, 0, 0, idle);
        step(0, 0, 0, idle);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_WIDTH, default 6, byte-address width of the target instruction memory; capacity = 2^(ADDR_WIDTH-2) words.
REQ-002 Ports (name  direction  width  meaning): clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 clear  in  1  synchronous soft clear of pointer, count and flags.
REQ-005 in_valid  in  1  descriptor valid.
REQ-006 in_ready  out  1  encoder accepts a descriptor this cycle.
REQ-007 op_class  in  3  000 R-type, 001 I-ALU, 010 lw, 011 sw, 100 branch; 101-111 illegal.
REQ-008 funct3  in  3  funct3 field (ignored for lw/sw).
REQ-009 funct7b5  in  1  instruction bit 30 (sub/sra/srai).
REQ-010 rd, rs1, rs2  in  5 each  register indices.
REQ-011 imm  in  13  signed immediate; I/S use imm[11:0]; B uses imm[12:1].
REQ-012 mem_we  out  1  instruction-memory write strobe.
REQ-013 mem_addr  out  ADDR_WIDTH  byte address, always word aligned.
REQ-014 mem_wdata  out  32  encoded instruction word.
REQ-015 count  out  ADDR_WIDTH-1  words written since reset/clear.
REQ-016 full  out  1  memory full, no further accepts.
REQ-017 err_illegal  out  1  sticky illegal-descriptor flag.

Function
REQ-018 FSM states ACCEPT, WRITE, FULL; handshake occurs when in_valid and in_ready are both high in ACCEPT.
REQ-019 in_ready shall be 1 only in ACCEPT with clear low.
REQ-020 Legal handshake: register encoded word, go to WRITE; next cycle mem_we=1, mem_addr=write pointer, mem_wdata=word (latency 1 cycle, throughput 1 per 2 cycles).
REQ-021 WRITE exit: pointer += 4, count += 1; go to FULL if the write used the last word, else to ACCEPT.
REQ-022 R-type encoding: {0,funct7b5,00000, rs2, rs1, funct3, rd, 0110011}.
REQ-023 I-ALU encoding: {imm[11:0], rs1, funct3, rd, 0010011}; for funct3 001/101 bits[31:25] = {0,funct7b5,00000} and bits[24:20] = imm[4:0].
REQ-024 lw encoding: {imm[11:0], rs1, 010, rd, 0000011}; sw encoding: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
REQ-025 Branch encoding: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
REQ-026 Illegal descriptor (op_class 101-111, branch with imm[0]=1, or branch funct3 010/011): handshake completes, no write, pointer unchanged, err_illegal set, state stays ACCEPT.
REQ-027 FULL: in_ready=0 and mem_we=0 until rst or clear; pointer wraps to 0 only through clear/rst.
REQ-028 clear has priority over handshake and pending write: next state ACCEPT; pointer, count, full and err_illegal go to 0; any WRITE-state write is dropped (mem_we=0 that cycle).
REQ-029 mem_we shall never be high in two consecutive cycles.

Reset
REQ-030 On rst: state ACCEPT, pointer 0, count 0, full 0, err_illegal 0, mem_we 0, mem_addr 0, mem_wdata 0; rst dominates clear.
REQ-031 rst mid-WRITE drops the pending write.

Structure
REQ-032 Shared package holds the opcode constants (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011), the op_class enum and the FSM state enum, shared with the main decoder.
REQ-033 One combinational sub-module instr_field_pack (descriptor -> 32-bit word + illegal flag); the FSM, pointer and flags live in instr_encoder.

Verification
REQ-034 R add x3,x1,x2 (funct3 0, funct7b5 0) -> one cycle later mem_we=1, addr 0x00, wdata 0x002081B3; with funct7b5=1 -> 0x402081B3.
REQ-035 lw x5,8(x2) then beq x1,x2,imm=-4 -> 0x00812283 at addr 0x00, 0xFE208EE3 at addr 0x04, count=2.
REQ-036 op_class 110 -> no mem_we, err_illegal=1, count unchanged; next legal descriptor written at the unchanged address.
REQ-037 ADDR_WIDTH=4, five back-to-back descriptors -> four writes at 0x0,0x4,0x8,0xC, full=1, in_ready=0, fifth never accepted.
REQ-038 clear asserted in WRITE cycle -> mem_we=0, count=0, full=0, next write at addr 0x00.
REQ-039 rst asserted with in_valid=1 and clear=1 -> all outputs at reset values next cycle, no handshake.
